inv_response_monitor: RTL and testbench
=======================================

// Module: inv_response_monitor
// PURPOSE
//   Board-side checker at the far end of the stimulus->inverter path. It is the observer for
//   the signal that a clock-driven stimulus feeds into a NOT gate.
//   Samples the DUT output (resp) against the drive (stim) and checks resp == ~stim.
//   It also counts resp edges over a fixed window and reports pass/fail plus counts.
//   Sits beside the myNot DUT on the Elbert V2 top level. Results drive LEDs/7-seg.
// PARAMETERS
//   WINDOW       1024  measurement length in clock cycles (>=1)
//   SETTLE       4     cycles ignored after start, before measuring (>=0)
//   SYNC_STAGES  2     flops in the resp/stim synchroniser and alignment chains (>=2)
//   CNT_W        16    width of edge/error/first-fail counters
// PORTS
//   clock       in   1      single system clock; all logic on rising edge
//   reset       in   1      synchronous, active-high reset
//   start       in   1      1-cycle request; accepted only in IDLE
//   stim        in   1      signal driven into DUT (same clock domain)
//   resp        in   1      DUT output (treated as asynchronous)
//   busy        out  1      high in SETTLE and MEASURE
//   done        out  1      1-cycle pulse when results are valid
//   pass        out  1      run passed (held until next accepted start)
//   edge_count  out  CNT_W  resp transitions seen in window (held)
//   err_count   out  CNT_W  mismatch cycles seen in window (held)
//   first_fail  out  CNT_W  window cycle index of first mismatch (FAIL_CAPTURE_EN only)
// BEHAVIOUR
//   - Reset: state=IDLE. busy, done, pass, edge_count, err_count, first_fail = 0. Chains cleared.
//   - resp passes through a SYNC_STAGES-flop chain -> resp_s.
//     stim passes through an equal-length chain -> stim_d, so both are aligned.
//   - mismatch = (resp_s == stim_d).
//     edge = (resp_s != resp_s_q), where resp_s_q is resp_s delayed one cycle.
//   - FSM states:
//       IDLE    -> SETTLE on start. Clears counts, pass and first_fail. Loads the settle counter.
//       SETTLE  -> MEASURE after SETTLE cycles. SETTLE=0 means one pass-through cycle.
//       MEASURE -> REPORT after exactly WINDOW cycles. Samples count only in MEASURE.
//       REPORT  -> IDLE unconditionally. done=1 for this cycle only.
//   - Latency: start is sampled high at edge k. busy=1 from k+1. The done pulse is registered
//     so it is visible in cycle k+2+SETTLE+WINDOW, and busy=0 in that same cycle.
//   - In REPORT: pass = (err_count==0) && (edge_count!=0).
//   - Counters saturate at {CNT_W{1'b1}} and never wrap.
//     The window/settle counter width is computed with a local clog2 function.
//   - start is ignored in SETTLE, MEASURE and REPORT: no queueing, no restart.
//     A start coincident with REPORT is dropped. A new start is needed in IDLE.
//   - reset mid-run: next cycle is IDLE with all outputs 0. No done pulse.
//   - Outputs hold their values in IDLE until the next accepted start.
// CONFIGURATION
//   FAIL_CAPTURE_EN defined:
//     - first_fail port exists.
//     - On the first mismatch of a run, first_fail latches the MEASURE cycle index (0-based).
//     - It stays 0 if there is no mismatch.
//   FAIL_CAPTURE_EN undefined:
//     - first_fail port and its register are absent.
//     - All other behaviour is identical.
// STRUCTURE
//   - Shared include monitor_defs.vh holds the FSM encodings:
//     ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_MEASURE=2'd2, ST_REPORT=2'd3.
//     It also holds the clog2 function.
//   - One sub-module: sync_chain #(STAGES) with ports clock, reset, d, q.
//     It is used twice, for resp and for stim alignment.
//   - FSM, counters and saturation logic live in the top module.
// TESTING  (WINDOW=16, SETTLE=4, SYNC_STAGES=2, CNT_W=16 unless noted)
//   1 Reset held 3 cycles, inputs random -> busy=done=pass=0, edge_count=err_count=0.
//   2 stim toggles every cycle, resp=~stim, start pulse -> done pulse 22 cycles after start edge;
//     edge_count=16, err_count=0, pass=1.
//   3 stim toggles, resp=stim (buffer DUT) -> err_count=16, pass=0; first_fail=0 with FAIL_CAPTURE_EN.
//   4 stim=1, resp=0 constant -> edge_count=0, err_count=0, pass=0 (no activity).
//   5 reset asserted at MEASURE cycle 8 -> next cycle busy=0 and counts=0, no done.
//     A following start completes as in test 2.
//   6 CNT_W=4, WINDOW=32, resp=stim; plus start re-pulsed during MEASURE
//     -> err_count=15 (saturated), single done pulse.

Source files
------------

// File: rtl/inv_response_monitor_pkg.sv
// -----------------------------------------------------------------------------
// inv_response_monitor_pkg
//   Shared definitions for the inverter response monitor:
//     - FSM state encoding (IDLE/SETTLE/MEASURE/REPORT)
//     - clog2 helper used to size the settle/window timer
//   Imported by inv_response_monitor and sync_chain.
// -----------------------------------------------------------------------------
package inv_response_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } state_e;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_response_monitor_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   STAGES-deep flop chain. Used as a metastability synchroniser for the
//   asynchronous DUT response and, with the same depth, as a pure delay line
//   for the stimulus so both arrive aligned at the comparator.
//   Ports:
//     clock  in  system clock (rising edge)
//     reset  in  synchronous active-high reset, clears the chain
//     d      in  input bit
//     q      out d delayed by STAGES clocks
// -----------------------------------------------------------------------------
module sync_chain
  import inv_response_monitor_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/inv_response_monitor.sv
// -----------------------------------------------------------------------------
// inv_response_monitor
//   Far-end checker for a stimulus -> NOT gate path. After a start request it
//   waits SETTLE cycles, then for WINDOW cycles compares the synchronised DUT
//   response against the equally delayed stimulus (expecting resp == ~stim)
//   and counts response edges. Results are reported with a one-cycle done
//   pulse and held until the next accepted start.
//
//   Optional feature macro: FAIL_CAPTURE_EN
//     defined   -> first_fail port exists and latches the MEASURE cycle index
//                  (0-based) of the first mismatch of a run.
//     undefined -> first_fail port and register are absent.
//
//   Ports:
//     clock       in   system clock, rising edge
//     reset       in   synchronous active-high reset
//     start       in   1-cycle run request, honoured only in IDLE
//     stim        in   signal driven into the DUT (clock domain)
//     resp        in   DUT output (asynchronous)
//     busy        out  high while settling or measuring
//     done        out  1-cycle pulse when results are valid
//     pass        out  no mismatches and at least one response edge
//     edge_count  out  response transitions in the window (saturating)
//     err_count   out  mismatch cycles in the window (saturating)
//     first_fail  out  window index of first mismatch (FAIL_CAPTURE_EN only)
// -----------------------------------------------------------------------------
module inv_response_monitor
  import inv_response_monitor_pkg::*;
#(
  parameter int WINDOW      = 1024,
  parameter int SETTLE      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stim,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] err_count
`ifdef FAIL_CAPTURE_EN
  ,
  output logic [CNT_W-1:0] first_fail
`endif
);

  // One timer serves both phases: it counts down through SETTLE and up
  // through MEASURE (where its value is the window index).
  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = (clog2(TMR_MAX + 1) < 1) ? 1 : clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] WIN_LAST  = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_ONE;
  endfunction

  // Window index narrowed to CNT_W bits, clamped rather than truncated.
  function automatic logic [CNT_W-1:0] sat_idx(input logic [TMR_W-1:0] idx);
    logic [63:0] wide;
    wide = 64'(idx);
    return (wide > 64'(CNT_MAX)) ? CNT_MAX : CNT_W'(idx);
  endfunction

  // Input alignment: resp is synchronised, stim delayed by the same depth.
  logic resp_s;
  logic stim_d;
  logic resp_s_q;

  sync_chain #(.STAGES(SYNC_STAGES)) u_resp_sync (
    .clock (clock),
    .reset (reset),
    .d     (resp),
    .q     (resp_s)
  );

  sync_chain #(.STAGES(SYNC_STAGES)) u_stim_align (
    .clock (clock),
    .reset (reset),
    .d     (stim),
    .q     (stim_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_s_q <= 1'b0;
    end else begin
      resp_s_q <= resp_s;
    end
  end

  // A healthy inverter never shows resp equal to stim.
  logic mismatch;
  logic edge_seen;

  assign mismatch  = (resp_s == stim_d);
  assign edge_seen = (resp_s != resp_s_q);

  // Control and result registers.
  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q,   tmr_d;
  logic [CNT_W-1:0]   edge_q,  edge_d;
  logic [CNT_W-1:0]   err_q,   err_d;
  logic               pass_q,  pass_d;
  logic               done_q,  done_d;
  logic               busy_q,  busy_d;
`ifdef FAIL_CAPTURE_EN
  logic [CNT_W-1:0]   ff_q,    ff_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      edge_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FAIL_CAPTURE_EN
      ff_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      edge_q  <= edge_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef FAIL_CAPTURE_EN
      ff_q    <= ff_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    edge_d  = edge_q;
    err_d   = err_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
`ifdef FAIL_CAPTURE_EN
    ff_d    = ff_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          tmr_d   = SETTLE_LD;
          edge_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
`ifdef FAIL_CAPTURE_EN
          ff_d    = '0;
`endif
        end
      end

      ST_SETTLE: begin
        // A load of 0 or 1 both leave after this cycle, so SETTLE=0 still
        // spends one pass-through cycle here.
        if (tmr_q <= TMR_ONE) begin
          state_d = ST_MEASURE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      ST_MEASURE: begin
        if (edge_seen) edge_d = sat_inc(edge_q);
        if (mismatch) begin
          err_d = sat_inc(err_q);
`ifdef FAIL_CAPTURE_EN
          // err_q still zero means this is the first mismatch of the run.
          if (err_q == '0) ff_d = sat_idx(tmr_q);
`endif
        end
        if (tmr_q == WIN_LAST) begin
          state_d = ST_REPORT;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end

      ST_REPORT: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        pass_d  = (err_q == '0) && (edge_q != '0);
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign edge_count = edge_q;
  assign err_count  = err_q;
`ifdef FAIL_CAPTURE_EN
  assign first_fail = ff_q;
`endif

endmodule

// File: tb/tb_inv_response_monitor.sv
module tb_inv_response_monitor;

  localparam int S   = 4;
  localparam int SS  = 2;
  localparam int WA  = 16;
  localparam int CA  = 16;
  localparam int WB  = 32;
  localparam int CB  = 4;
  localparam int LEN = S + WB + 3;

  typedef struct {
    int     edges;
    int     errs;
    int     pass;
    int     ff;
    longint due;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, stim, resp;

  logic          busy_a, done_a, pass_a;
  logic [CA-1:0] edge_a, err_a, ff_a;
  logic          busy_b, done_b, pass_b;
  logic [CB-1:0] edge_b, err_b, ff_b;

  bit     seq_s [LEN];
  bit     seq_p [LEN];
  exp_t   qa[$];
  exp_t   qb[$];
  longint cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifndef FAIL_CAPTURE_EN
  assign ff_a = '0;
  assign ff_b = '0;
`endif

  inv_response_monitor #(.WINDOW(WA), .SETTLE(S), .SYNC_STAGES(SS), .CNT_W(CA)) dut_a (
    .clock      (clk),
    .reset      (reset),
    .start      (start),
    .stim       (stim),
    .resp       (resp),
    .busy       (busy_a),
    .done       (done_a),
    .pass       (pass_a),
    .edge_count (edge_a),
    .err_count  (err_a)
`ifdef FAIL_CAPTURE_EN
    ,
    .first_fail (ff_a)
`endif
  );

  inv_response_monitor #(.WINDOW(WB), .SETTLE(S), .SYNC_STAGES(SS), .CNT_W(CB)) dut_b (
    .clock      (clk),
    .reset      (reset),
    .start      (start),
    .stim       (stim),
    .resp       (resp),
    .busy       (busy_b),
    .done       (done_b),
    .pass       (pass_b),
    .edge_count (edge_b),
    .err_count  (err_b)
`ifdef FAIL_CAPTURE_EN
    ,
    .first_fail (ff_b)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the sample taken in window slot j reflects the inputs
  // applied SS edges earlier; measuring begins SETTLE+1 edges after start.
  function automatic exp_t model(input int win, input int cw, input longint k);
    exp_t e;
    int   satv, r;
    bit   found;
    satv  = (1 << cw) - 1;
    e.edges = 0; e.errs = 0; e.ff = 0; found = 0;
    for (int j = 0; j < win; j++) begin
      r = S + 1 + j - SS;
      if (seq_p[r] != seq_p[r-1]) e.edges++;
      if (seq_p[r] == seq_s[r]) begin
        if (!found) e.ff = j;
        found = 1;
        e.errs++;
      end
    end
    if (e.edges > satv) e.edges = satv;
    if (e.errs  > satv) e.errs  = satv;
    if (e.ff    > satv) e.ff    = satv;
    e.pass = (e.errs == 0 && e.edges != 0) ? 1 : 0;
    e.due  = k + S + win + 1;
    return e;
  endfunction

  task automatic cmp_run(input string tag, input exp_t e, input longint edges,
                         input longint errs, input longint p, input longint ff);
    check({tag, "_done_cycle"}, cyc, e.due);
    check({tag, "_edge_count"}, edges, e.edges);
    check({tag, "_err_count"}, errs, e.errs);
    check({tag, "_pass"}, p, e.pass);
`ifdef FAIL_CAPTURE_EN
    check({tag, "_first_fail"}, ff, e.ff);
`endif
  endtask

  // Scoreboard monitor: pops an expectation whenever a DUT presents done,
  // and flags expectations whose due cycle has passed.
  always @(negedge clk) begin
    exp_t e;
    if (done_a) begin
      check("A_done_expected", qa.size() > 0, 1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp_run("A", e, edge_a, err_a, pass_a, ff_a);
      end
    end else if (qa.size() > 0 && cyc > qa[0].due) begin
      e = qa.pop_front();
      check("A_done_timeout", 0, 1);
    end
    if (done_b) begin
      check("B_done_expected", qb.size() > 0, 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp_run("B", e, edge_b, err_b, pass_b, ff_b);
      end
    end else if (qb.size() > 0 && cyc > qb[0].due) begin
      e = qb.pop_front();
      check("B_done_timeout", 0, 1);
    end
  end

  task automatic gen(input int mode);
    int flip;
    flip = $urandom_range(S + 1 - SS, LEN - 1);
    for (int r = 0; r < LEN; r++) begin
      case (mode)
        0: begin seq_s[r] = r[0]; seq_p[r] = ~r[0]; end
        1: begin seq_s[r] = r[0]; seq_p[r] = r[0]; end
        2: begin seq_s[r] = 1'b1; seq_p[r] = 1'b0; end
        3: begin seq_s[r] = 1'($urandom); seq_p[r] = ~seq_s[r]; end
        4: begin seq_s[r] = 1'($urandom); seq_p[r] = 1'($urandom); end
        default: begin
          seq_s[r] = r[0];
          seq_p[r] = (r == flip) ? r[0] : ~r[0];
        end
      endcase
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy_a"}, busy_a, 0);
    check({tag, "_done_a"}, done_a, 0);
    check({tag, "_pass_a"}, pass_a, 0);
    check({tag, "_edge_a"}, edge_a, 0);
    check({tag, "_err_a"},  err_a, 0);
    check({tag, "_busy_b"}, busy_b, 0);
    check({tag, "_edge_b"}, edge_b, 0);
    check({tag, "_err_b"},  err_b, 0);
  endtask

  // One run: stimulus pre-generated, expectations pushed, then played out.
  // repulse re-asserts start mid-MEASURE; rep_start asserts start while A is
  // in REPORT; abort_r >= 0 applies reset at that edge instead of finishing.
  task automatic run(input int mode, input bit repulse, input bit rep_start, input int abort_r);
    longint k;
    gen(mode);
    k = cyc + 1;
    if (abort_r < 0) begin
      qa.push_back(model(WA, CA, k));
      qb.push_back(model(WB, CB, k));
    end
    for (int r = 0; r < LEN; r++) begin
      stim  = seq_s[r];
      resp  = seq_p[r];
      start = (r == 0) || (repulse && r == 10) || (rep_start && r == S + WA + 1);
      if (r == abort_r) begin
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_zero("midrun_reset");
        reset = 1'b0;
        break;
      end
      @(negedge clk);
      check("A_busy", busy_a, (r < S + WA) ? 1 : 0);
      check("B_busy", busy_b, (r < S + WB) ? 1 : 0);
    end
    start = 1'b0;
    repeat (3) begin
      stim = 1'($urandom);
      resp = 1'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stim  = 1'b0;
    resp  = 1'b0;
    repeat (3) begin
      stim  = 1'($urandom);
      resp  = 1'($urandom);
      start = 1'($urandom);
      @(negedge clk);
    end
    check_zero("reset");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    run(0, 0, 0, -1);
    run(1, 0, 0, -1);
    run(2, 0, 0, -1);
    run(0, 1, 1, -1);
    run(0, 0, 0, S + 1 + 8);
    run(0, 0, 0, -1);
    for (int i = 0; i < 10; i++) begin
      run($urandom_range(0, 5), 1'($urandom), 1'b0, -1);
    end

    repeat (5) @(negedge clk);
    check("A_queue_drained", qa.size(), 0);
    check("B_queue_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
